// File: rtl/jk_counter_sequencer.sv
// jk_counter_sequencer: start/stop/pause sequencer around a JK-flip-flop counter
// with programmable terminal count, up/down direction and one-shot or auto-reload.
module jk_counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_DONE = 2'b11} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_count, r_limit;
  logic             r_dir, r_reload, r_done, r_wrap;
  logic             w_load, w_step, w_sample, w_done, w_wrap, w_term;
  logic [WIDTH-1:0] w_load_val, w_t, w_j, w_k;
  assign w_term = r_dir ? (r_count == '0) : (r_count == r_limit);
  // Toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_t
    if (i == 0) begin : g_lsb
      assign w_t[i] = w_step;
    end else begin : g_bit
      assign w_t[i] = w_step & (r_dir ? ~|r_count[i-1:0] : &r_count[i-1:0]);
    end
  end
  // Load overrides the toggle path with J=value, K=~value; no step means J=K=0.
  assign w_j = w_load ? w_load_val : w_t;
  assign w_k = w_load ? ~w_load_val : w_t;
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = r_dir ? r_limit : '0;
    w_step     = 1'b0;
    w_sample   = 1'b0;
    w_done     = 1'b0;
    w_wrap     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (stop) w_next = S_IDLE;
        else if (start) begin
          w_sample   = 1'b1;
          w_load     = 1'b1;
          w_load_val = dir ? limit : '0;
          w_next     = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) w_next = S_IDLE;
        else if (pause) w_next = S_HOLD;
        else if (w_term) begin
          if (r_reload) begin
            w_load = 1'b1;
            w_wrap = 1'b1;
          end else begin
            w_next = S_DONE;
            w_done = 1'b1;
          end
        end else w_step = 1'b1;
      end
      S_HOLD: w_next = stop ? S_IDLE : (pause ? S_HOLD : S_RUN);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_limit  <= '0;
      r_dir    <= 1'b0;
      r_reload <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= (w_j & ~r_count) | (~w_k & r_count);
      r_done  <= w_done;
      r_wrap  <= w_wrap;
      if (w_sample) begin
        r_limit  <= limit;
        r_dir    <= dir;
        r_reload <= reload;
      end
    end
  end
  assign count = r_count;
  assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done  = r_done;
  assign wrap  = r_wrap;
  assign state = r_state;
endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb_jk_counter_sequencer: scoreboard bench; a behavioural model queues the
// expected post-edge outputs for each driven cycle and they are checked after the edge.
module tb_jk_counter_sequencer;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, stop, pause, dir, reload;
  logic [W-1:0] limit, count;
  logic         busy, done, wrap;
  logic [1:0]   state;
  int           n_vec = 0;
  int           n_err = 0;
  typedef struct packed {
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         wrap;
  } exp_t;
  exp_t         sb_q[$];
  logic [1:0]   m_st;
  logic [W-1:0] m_cnt, m_lim;
  logic         m_dir, m_rel;
  jk_counter_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .reload(reload), .limit(limit), .count(count), .busy(busy),
    .done(done), .wrap(wrap), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 2'b00; m_cnt = '0; m_lim = '0; m_dir = 1'b0; m_rel = 1'b0;
  endtask
  task automatic step();
    exp_t       e, g;
    logic [1:0] ns;
    logic       nd, nw;
    ns = m_st; nd = 1'b0; nw = 1'b0;
    case (m_st)
      2'b00, 2'b11: begin
        if (stop) ns = 2'b00;
        else if (start) begin
          m_dir = dir; m_rel = reload; m_lim = limit;
          m_cnt = dir ? limit : '0;
          ns = 2'b01;
        end
      end
      2'b01: begin
        if (stop) ns = 2'b00;
        else if (pause) ns = 2'b10;
        else if (m_dir ? (m_cnt == 0) : (m_cnt == m_lim)) begin
          if (m_rel) begin
            m_cnt = m_dir ? m_lim : '0;
            nw = 1'b1;
          end else begin
            ns = 2'b11;
            nd = 1'b1;
          end
        end else m_cnt = m_dir ? m_cnt - 1'b1 : m_cnt + 1'b1;
      end
      default: ns = stop ? 2'b00 : (pause ? 2'b10 : 2'b01);
    endcase
    m_st = ns;
    e = '{ns, m_cnt, (ns == 2'b01 || ns == 2'b10), nd, nw};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("state", state, g.st);
    chk("count", count, g.cnt);
    chk("busy", busy, g.busy);
    chk("done", done, g.done);
    chk("wrap", wrap, g.wrap);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic go(input logic d, input logic r, input logic [W-1:0] l);
    dir = d; reload = r; limit = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    {start, stop, pause, dir, reload} = '0;
    limit = '0;
    model_reset();
    #12;
    chk("rst_count", count, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pause = 1'b1;
    steps(2);
    pause = 1'b0;
    // Up one-shot, limit 3: done lands L+1 = 4 edges after the start edge.
    go(1'b0, 1'b0, 4'd3);
    steps(3);
    chk("up_cnt3", count, 3);
    step();
    chk("up_done", done, 1);
    chk("up_st", state, 2'b11);
    steps(2);
    chk("up_hold", count, 3);
    // Restart from DONE, limit changed mid-run must not move the terminal.
    go(1'b0, 1'b0, 4'd3);
    limit = 4'd7;
    steps(5);
    chk("lim_smp_st", state, 2'b11);
    chk("lim_smp_cnt", count, 3);
    // stop and start together in DONE: stop wins.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_win", state, 2'b00);
    // Down auto-reload, limit 2; a stray start mid-run is ignored.
    go(1'b1, 1'b1, 4'd2);
    steps(3);
    chk("wrap_pulse", wrap, 1);
    chk("wrap_cnt", count, 2);
    limit = 4'd9; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    steps(6);
    chk("dn_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    // Pause and stop on an up run, limit 9.
    go(1'b0, 1'b0, 4'd9);
    steps(4);
    chk("p_at4", count, 4);
    pause = 1'b1;
    steps(3);
    chk("p_hold_st", state, 2'b10);
    chk("p_hold_cnt", count, 4);
    pause = 1'b0;
    steps(2);
    chk("p_resume", count, 5);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_st", state, 2'b00);
    chk("stop_cnt", count, 6);
    steps(2);
    // limit 0 one-shot: done one edge after start.
    go(1'b0, 1'b0, 4'd0);
    step();
    chk("lim0_done", done, 1);
    // Full-scale limit: reach 15 without wrapping to 0.
    go(1'b0, 1'b0, 4'd15);
    steps(15);
    chk("lim15_cnt", count, 15);
    step();
    chk("lim15_done", done, 1);
    steps(2);
    chk("lim15_hold", count, 15);
    // Down one-shot from 5 plus a reload run starting from 0 in the down direction.
    go(1'b1, 1'b0, 4'd5);
    steps(7);
    go(1'b1, 1'b1, 4'd0);
    steps(3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    // Asynchronous reset mid-run at count 5, between clock edges.
    go(1'b0, 1'b0, 4'd9);
    steps(5);
    chk("pre_rst_cnt", count, 5);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_state", state, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    steps(2);
    go(1'b0, 1'b0, 4'd2);
    steps(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
